// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//
// Shared definitions for the RV32I core front end.
//
// Contents:
//   pcs_state_t      - state of the program-counter sequencer FSM
//   PC_RESET_VECTOR  - PC loaded when rst_n is asserted
//   PC_TRAP_VECTOR   - PC loaded when a control transfer lands misaligned
//   PC_STEP          - sequential instruction stride in bytes
//   pc_misaligned()  - true when an address is not on a 4-byte boundary
//                      for the purposes of control-transfer trapping
// ---------------------------------------------------------------------------
package rv32i_pkg;

    // BOOT absorbs the synchronous instruction-memory latency after reset.
    // TRAP is the single cycle in which the misalign trap is reported.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pcs_state_t;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0010;
    localparam logic [31:0] PC_STEP         = 32'h0000_0004;

    // Only bit 1 is checked. Bit 0 is cleared for JALR, and JAL/branch
    // immediates are always even, so bit 1 is the only bit that can break
    // 4-byte alignment of a control-transfer target.
    function automatic logic pc_misaligned(input logic [31:0] addr);
        return addr[1];
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// ---------------------------------------------------------------------------
// pc_target_sel
//
// Purely combinational target computation for the PC sequencer. Forms the
// JALR, JAL and branch targets, chooses one by priority and flags whether a
// non-sequential transfer was selected and whether its target is misaligned.
//
// Ports:
//   pc          in   32  current architectural PC
//   pc_plus4    in   32  pc + 4, the fall-through target
//   is_branch   in    1  conditional branch instruction
//   is_jal      in    1  JAL instruction
//   is_jalr     in    1  JALR instruction
//   take_branch in    1  branch condition result
//   imm         in   32  sign-extended immediate
//   rs1_val     in   32  rs1 value (JALR base)
//   target      out  32  selected next-PC candidate
//   taken       out   1  a non-sequential transfer was selected
//   misaligned  out   1  taken transfer whose target is not 4-byte aligned
// ---------------------------------------------------------------------------
module pc_target_sel
    import rv32i_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        take_branch,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic [31:0] target,
    output logic        taken,
    output logic        misaligned
);

    logic [31:0] jalr_sum;
    logic [31:0] jalr_target;
    logic [31:0] rel_target;

    // JALR clears bit 0 of the sum; JAL and branches share one pc-relative
    // adder since they never need distinct targets in the same cycle.
    always_comb begin
        jalr_sum    = rs1_val + imm;
        jalr_target = {jalr_sum[31:1], 1'b0};
        rel_target  = pc + imm;
    end

    // Priority JALR > JAL > taken branch > fall-through. take_branch is
    // only meaningful for conditional branches.
    always_comb begin
        target = pc_plus4;
        taken  = 1'b0;
        if (is_jalr) begin
            target = jalr_target;
            taken  = 1'b1;
        end else if (is_jal) begin
            target = rel_target;
            taken  = 1'b1;
        end else if (is_branch && take_branch) begin
            target = rel_target;
            taken  = 1'b1;
        end
    end

    // The fall-through path can never trap, so only taken transfers count.
    always_comb begin
        misaligned = taken && pc_misaligned(target);
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter stage of the RV32I core. Holds the architectural PC,
// selects the next PC from the branch/jump decision, traps misaligned
// control-transfer targets, inserts a one-cycle boot bubble after reset and
// counts retired instructions.
//
// Parameters:
//   RESET_VECTOR  PC value after reset
//   TRAP_VECTOR   PC value after a misaligned-target trap
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   instr_valid    in   1   decoded instruction at pc is valid
//   stall          in   1   hold the PC, no retire (wins over instr_valid)
//   is_branch      in   1   conditional branch
//   is_jal         in   1   JAL
//   is_jalr        in   1   JALR
//   take_branch    in   1   branch condition result
//   imm            in  32   sign-extended immediate
//   rs1_val        in  32   rs1 value for JALR
//   pc             out 32   registered architectural PC
//   pc_plus4       out 32   pc + 4 (link value)
//   next_pc        out 32   value pc takes at the next edge
//   redirect       out  1   non-sequential transfer committing this cycle
//   misalign_trap  out  1   one-cycle pulse while the trap is reported
//   trap_pc        out 32   PC of the last trapping instruction
//   instret        out 32   retired instruction count
// ---------------------------------------------------------------------------
module pc_sequencer
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = PC_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        take_branch,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        misalign_trap,
    output logic [31:0] trap_pc,
    output logic [31:0] instret
);

    pcs_state_t  state;
    pcs_state_t  state_next;

    logic [31:0] target;
    logic        taken;
    logic        misaligned;

    logic        update;
    logic        trap_now;
    logic        retire;

    always_comb begin
        pc_plus4 = pc + PC_STEP;
    end

    pc_target_sel u_target_sel (
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .is_branch   (is_branch),
        .is_jal      (is_jal),
        .is_jalr     (is_jalr),
        .take_branch (take_branch),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .target      (target),
        .taken       (taken),
        .misaligned  (misaligned)
    );

    // An instruction is only acted on in RUN; BOOT and TRAP are bubbles in
    // which every input is ignored. stall overrides instr_valid.
    always_comb begin
        update   = (state == RUN) && instr_valid && !stall;
        trap_now = update && misaligned;
        retire   = update && !misaligned;
    end

    // Next-state logic and the combinational PC outputs. next_pc is what the
    // PC register loads every cycle, so "no update" simply means next_pc = pc.
    always_comb begin
        state_next = state;
        next_pc    = pc;
        redirect   = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (trap_now) begin
                    next_pc    = TRAP_VECTOR;
                    state_next = TRAP;
                end else if (update) begin
                    next_pc  = target;
                    redirect = taken;
                end
            end
            TRAP: begin
                state_next = RUN;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Architectural PC; loads next_pc unconditionally since next_pc already
    // folds in the hold cases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= next_pc;
        end
    end

    // Trap reporting: the pulse is registered from the trapping cycle so it
    // is high exactly while the FSM sits in TRAP. trap_pc records the PC of
    // the offending instruction and holds until the next trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_trap <= 1'b0;
            trap_pc       <= 32'h0;
        end else begin
            misalign_trap <= trap_now;
            if (trap_now) begin
                trap_pc <= pc;
            end
        end
    end

    // Retired instruction counter; a trapping instruction does not retire.
    // Wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 32'h0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer: a directed walk through reset, boot,
// branches, jumps, traps, stalls and PC wrap, then randomized instruction
// streams with occasional mid-run resets. Expected values come from a
// behavioural reference model of the PC stage.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0010;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        stall;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        take_branch;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;
    logic        misalign_trap;
    logic [31:0] trap_pc;
    logic [31:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 = boot bubble, 1 = running, 2 = trap bubble.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_trap_pc;
    logic        m_trap_pulse;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .is_branch     (is_branch),
        .is_jal        (is_jal),
        .is_jalr       (is_jalr),
        .take_branch   (take_branch),
        .imm           (imm),
        .rs1_val       (rs1_val),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .misalign_trap (misalign_trap),
        .trap_pc       (trap_pc),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_mode       = 0;
        m_pc         = RST_VEC;
        m_instret    = 32'h0;
        m_trap_pc    = 32'h0;
        m_trap_pulse = 1'b0;
    endtask

    // Asserts reset in the middle of a cycle, checks that it takes effect
    // without a clock edge, then releases it well before the next edge.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_pc", pc, RST_VEC);
        checkOutput("rst_instret", instret, 32'h0);
        checkOutput("rst_trap", {31'h0, misalign_trap}, 32'h0);
        checkOutput("rst_trap_pc", trap_pc, 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    // Drives one cycle of inputs, checks all outputs against the model on
    // the falling edge, then advances the model at the rising edge.
    task automatic applyStimulus(input logic iv, input logic st, input logic br,
                                 input logic jal, input logic jalr, input logic tb,
                                 input logic [31:0] im, input logic [31:0] rs1);
        logic        upd;
        logic        tk;
        logic        trp;
        logic [31:0] tgt;
        logic [31:0] exp_next;
        instr_valid = iv;
        stall       = st;
        is_branch   = br;
        is_jal      = jal;
        is_jalr     = jalr;
        take_branch = tb;
        imm         = im;
        rs1_val     = rs1;

        upd = (m_mode == 1) && iv && !st;
        tk  = jalr || jal || (br && tb);
        if (jalr)
            tgt = (rs1 + im) & 32'hFFFF_FFFE;
        else if (jal || (br && tb))
            tgt = m_pc + im;
        else
            tgt = m_pc + 32'd4;
        trp = upd && tk && (tgt % 4 != 0);
        if (trp)
            exp_next = TRAP_VEC;
        else if (upd)
            exp_next = tgt;
        else
            exp_next = m_pc;

        @(negedge clk);
        checkOutput("pc", pc, m_pc);
        checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
        checkOutput("next_pc", next_pc, exp_next);
        checkOutput("redirect", {31'h0, redirect}, {31'h0, upd && tk && !trp});
        checkOutput("misalign_trap", {31'h0, misalign_trap}, {31'h0, m_trap_pulse});
        checkOutput("trap_pc", trap_pc, m_trap_pc);
        checkOutput("instret", instret, m_instret);

        @(posedge clk);
        m_trap_pulse = trp;
        if (trp) begin
            m_trap_pc = m_pc;
            m_mode    = 2;
        end else begin
            if (upd) m_instret = m_instret + 32'd1;
            m_mode = 1;
        end
        m_pc = exp_next;
        #1;
    endtask

    task automatic seqInstr();
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic setPc(input logic [31:0] addr);
        applyStimulus(1, 0, 0, 0, 1, 0, 32'h0, addr);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r_imm;
        logic [31:0] r_rs1;
        int          kind;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        stall       = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        take_branch = 1'b0;
        imm         = 32'h0;
        rs1_val     = 32'h0;
        modelReset();
        #6;
        doReset();

        // Boot bubble ignores a valid instruction, then sequential fetch.
        seqInstr();
        checkOutput("boot_hold", pc, 32'h0);
        seqInstr();
        checkOutput("boot_first", pc, 32'h4);

        // Mid-run reset from 0x40.
        setPc(32'h40);
        checkOutput("pc_0x40", pc, 32'h40);
        doReset();
        seqInstr();

        // Taken / not-taken backward branch.
        setPc(32'h100);
        applyStimulus(1, 0, 1, 0, 0, 1, 32'hFFFF_FFF0, 32'h0);
        checkOutput("br_taken", pc, 32'hF0);
        setPc(32'h100);
        applyStimulus(1, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h0);
        checkOutput("br_not_taken", pc, 32'h104);

        // JALR clears bit 0.
        setPc(32'h200);
        applyStimulus(1, 0, 0, 0, 1, 0, 32'h0, 32'h1001);
        checkOutput("jalr_bit0", pc, 32'h1000);

        // Misaligned JAL traps; the trap bubble ignores inputs.
        setPc(32'h300);
        applyStimulus(1, 0, 0, 1, 0, 0, 32'h6, 32'h0);
        checkOutput("trap_pulse", {31'h0, misalign_trap}, 32'h1);
        checkOutput("trap_pc_val", trap_pc, 32'h300);
        checkOutput("trap_vec", pc, TRAP_VEC);
        applyStimulus(1, 0, 0, 1, 0, 0, 32'h40, 32'h0);
        checkOutput("trap_end", {31'h0, misalign_trap}, 32'h0);
        seqInstr();
        checkOutput("after_trap", pc, 32'h14);

        // Stalled JAL holds, then retires with the inputs at release.
        setPc(32'h400);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1, 0, 0, 32'h20, 32'h0);
        checkOutput("stall_hold", pc, 32'h400);
        applyStimulus(1, 0, 0, 1, 0, 0, 32'h20, 32'h0);
        checkOutput("stall_release", pc, 32'h420);
        applyStimulus(1, 0, 0, 1, 1, 0, 32'h8, 32'h500);
        checkOutput("jalr_wins", pc, 32'h508);

        // PC wraps modulo 2^32.
        setPc(32'hFFFF_FFFC);
        seqInstr();
        checkOutput("pc_wrap", pc, 32'h0);

        // Randomized instruction stream with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end
            kind  = $urandom_range(0, 5);
            r_imm = ($urandom_range(0, 7) == 0) ? 32'($signed($urandom_range(0, 127)) - 64) * 2
                                                : 32'($signed($urandom_range(0, 127)) - 64) * 4;
            r_rs1 = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + ($urandom & 32'hF)
                                                : $urandom & 32'h0000_FFFF;
            case (kind)
                0: applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                                 0, 0, 0, 1'($urandom), r_imm, r_rs1);
                1, 2: applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                                 1, 0, 0, 1'($urandom), r_imm, r_rs1);
                3: applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                                 0, 1, 0, 1'($urandom), r_imm, r_rs1);
                4: applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                                 0, 0, 1, 1'($urandom), r_imm, r_rs1);
                default: applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                 1'($urandom), 1'($urandom), r_imm, r_rs1);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
